// File: rtl/button_pkg.sv
// Shared definitions for the button conditioning slice: debounce FSM
// state encoding and the default stability window.
package button_pkg;

  // Debounce FSM states. The encoding is exposed on the debug outputs.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_e;

  // 10 ms stability window at a 12 MHz system clock.
  localparam int unsigned debounce_default_c = 120000;

endpackage : button_pkg

// File: rtl/debounce_bit.sv
// Single-channel button conditioner: two-flop synchronizer, a four-state
// debounce FSM with a saturating stability counter, and registered
// level / press / release outputs.
module debounce_bit
  import button_pkg::*;
#(
  parameter int unsigned debounce_cycles_p = debounce_default_c
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      button_async_unsafe_i,
  output logic      btn_o,
  output logic      press_o,
  output logic      release_o,
  output db_state_e state_o
);

  localparam int unsigned cnt_w = $clog2(debounce_cycles_p);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(debounce_cycles_p - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q;
  db_state_e        state_n;
  logic [cnt_w-1:0] cnt_q;
  logic [cnt_w-1:0] cnt_n;
  logic             btn_q;
  logic             btn_n;
  logic             press_q;
  logic             press_n;
  logic             release_q;
  logic             release_n;

  // Two-flop synchronizer; only sync2_q is seen by the FSM.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_async_unsafe_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and output decode. The counter is cleared on
  // entry to a pending state and stops at cnt_max, so it never wraps.
  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q) state_n = PEND_HI;
      end
      PEND_HI: begin
        if (!sync2_q)            state_n = STABLE_LO;
        else if (cnt_q == cnt_max) state_n = STABLE_HI;
        else                     cnt_n   = cnt_q + cnt_w'(1);
      end
      STABLE_HI: begin
        if (!sync2_q) state_n = PEND_LO;
      end
      PEND_LO: begin
        if (sync2_q)             state_n = STABLE_HI;
        else if (cnt_q == cnt_max) state_n = STABLE_LO;
        else                     cnt_n   = cnt_q + cnt_w'(1);
      end
      default: begin
        state_n = STABLE_LO;
      end
    endcase
    btn_n     = (state_n == STABLE_HI) || (state_n == PEND_LO);
    press_n   = (state_q == PEND_HI) && (state_n == STABLE_HI);
    release_n = (state_q == PEND_LO) && (state_n == STABLE_LO);
  end

  // State, counter and registered outputs; reset abandons any pending edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      btn_q     <= btn_n;
      press_q   <= press_n;
      release_q <= release_n;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign state_o   = state_q;

endmodule : debounce_bit

// File: rtl/button_conditioner.sv
// Conditions width_p independent raw buttons into clean levels plus
// press/release pulses. Each channel is its own debounce_bit instance;
// per-channel FSM states are packed onto dbg_state_o (2 bits per channel).
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned width_p           = 3,
  parameter int unsigned debounce_cycles_p = debounce_default_c
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     button_async_unsafe_i,
  output logic [width_p-1:0]     btn_o,
  output logic [width_p-1:0]     press_o,
  output logic [width_p-1:0]     release_o,
  output logic [2*width_p-1:0]   dbg_state_o
);

  for (genvar g = 0; g < int'(width_p); g++) begin : g_chan
    db_state_e state_w;

    debounce_bit #(
      .debounce_cycles_p(debounce_cycles_p)
    ) u_debounce_bit (
      .clk_i                (clk_i),
      .reset_n_i            (reset_n_i),
      .button_async_unsafe_i(button_async_unsafe_i[g]),
      .btn_o                (btn_o[g]),
      .press_o              (press_o[g]),
      .release_o            (release_o[g]),
      .state_o              (state_w)
    );

    assign dbg_state_o[2*g +: 2] = state_w;
  end

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle window, 3 channels.
// Edge k of a scenario is the k-th rising edge after its inputs are applied.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int unsigned w_c = 3;
  localparam int unsigned d_c = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [w_c-1:0] button_async_unsafe_i;
  logic [w_c-1:0] btn_o;
  logic [w_c-1:0] press_o;
  logic [w_c-1:0] release_o;
  logic [2*w_c-1:0] dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario tables: stimulus per edge and expected {btn, press, release}.
  logic [w_c-1:0]   stim_q[$];
  logic [3*w_c-1:0] exp_q[$];

  button_conditioner #(
    .width_p          (w_c),
    .debounce_cycles_p(d_c)
  ) dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .button_async_unsafe_i(button_async_unsafe_i),
    .btn_o                (btn_o),
    .press_o              (press_o),
    .release_o            (release_o),
    .dbg_state_o          (dbg_state_o)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [2:0] stim, input logic [2:0] btn,
                      input logic [2:0] prs, input logic [2:0] rel);
    stim_q.push_back(stim);
    exp_q.push_back({btn, prs, rel});
  endtask

  // Drives each queued stimulus for one edge and checks the outputs after it.
  task automatic play(input string name);
    int k = 0;
    logic [2:0] s;
    logic [8:0] e;
    while (stim_q.size() > 0) begin
      k++;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      button_async_unsafe_i = s;
      tick();
      check($sformatf("%s e%0d btn", name, k), 32'(btn_o), 32'(e[8:6]));
      check($sformatf("%s e%0d press", name, k), 32'(press_o), 32'(e[5:3]));
      check($sformatf("%s e%0d release", name, k), 32'(release_o), 32'(e[2:0]));
      check($sformatf("%s e%0d excl", name, k), 32'(press_o & release_o), 32'd0);
    end
  endtask

  initial begin
    int glen;
    reset_n_i = 1'b0;
    button_async_unsafe_i = '0;
    tick();
    tick();
    check("reset btn", 32'(btn_o), 32'd0);
    check("reset press", 32'(press_o), 32'd0);
    check("reset release", 32'(release_o), 32'd0);
    check("reset state", 32'(dbg_state_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    tick();

    // Clean step on bit0: level and pulse at edge 7.
    for (int k = 1; k <= 9; k++)
      push(3'b001, (k >= 7) ? 3'b001 : 3'b000, (k == 7) ? 3'b001 : 3'b000, 3'b000);
    play("step");

    // Release bit0: level drops and release pulses at edge 7.
    for (int k = 1; k <= 9; k++)
      push(3'b000, (k < 7) ? 3'b001 : 3'b000, 3'b000, (k == 7) ? 3'b001 : 3'b000);
    play("release");

    // Bounce on bit1: high 3, low 1, high from edge 5 -> one press at edge 11.
    for (int k = 1; k <= 14; k++)
      push((k <= 3 || k >= 5) ? 3'b010 : 3'b000, (k >= 11) ? 3'b010 : 3'b000,
           (k == 11) ? 3'b010 : 3'b000, 3'b000);
    play("bounce");

    // Glitches on bit2 of 2 and d_c cycles: nothing happens, bit1 unaffected.
    for (int g = 0; g < 2; g++) begin
      glen = (g == 0) ? 2 : int'(d_c);
      for (int k = 1; k <= 10; k++)
        push((k <= glen) ? 3'b110 : 3'b010, 3'b010, 3'b000, 3'b000);
      play($sformatf("glitch%0d", glen));
    end

    // Bit2 high for d_c+1 cycles is just long enough: press at 7, release at 12.
    for (int k = 1; k <= 14; k++)
      push((k <= 5) ? 3'b110 : 3'b010, (k >= 7 && k < 12) ? 3'b110 : 3'b010,
           (k == 7) ? 3'b100 : 3'b000, (k == 12) ? 3'b100 : 3'b000);
    play("edge5");

    // Release bit1 to return to all-low.
    for (int k = 1; k <= 9; k++)
      push(3'b000, (k < 7) ? 3'b010 : 3'b000, 3'b000, (k == 7) ? 3'b010 : 3'b000);
    play("rel1");

    // All channels rise together, then fall together.
    for (int k = 1; k <= 9; k++)
      push(3'b111, (k >= 7) ? 3'b111 : 3'b000, (k == 7) ? 3'b111 : 3'b000, 3'b000);
    play("conc_rise");
    for (int k = 1; k <= 9; k++)
      push(3'b000, (k < 7) ? 3'b111 : 3'b000, 3'b000, (k == 7) ? 3'b111 : 3'b000);
    play("conc_fall");

    // Reset at edge 5 of a pending press on bit0.
    for (int k = 1; k <= 4; k++)
      push(3'b001, 3'b000, 3'b000, 3'b000);
    play("pend");
    check("pend state", 32'(dbg_state_o[1:0]), 32'(PEND_HI));
    @(posedge clk_i);
    reset_n_i = 1'b0;
    #1;
    check("rst_mid btn", 32'(btn_o), 32'd0);
    check("rst_mid press", 32'(press_o), 32'd0);
    check("rst_mid state", 32'(dbg_state_o), 32'd0);
    tick();
    tick();
    check("rst_hold press", 32'(press_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int k = 1; k <= 9; k++)
      push(3'b001, (k >= 7) ? 3'b001 : 3'b000, (k == 7) ? 3'b001 : 3'b000, 3'b000);
    play("post_rst");

    // Reset while a level is high clears it without waiting for an edge.
    #2;
    reset_n_i = 1'b0;
    #1;
    check("rst_async btn", 32'(btn_o), 32'd0);
    check("rst_async release", 32'(release_o), 32'd0);
    check("rst_async state", 32'(dbg_state_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_button_conditioner
